// File: rtl/pair_select_fsm.sv
// ---------------------------------------------------------------------------
// pair_select_fsm
//   Turn controller for the 16-card memory game. It records the two cards a
//   player picks, compares their symbols, then either locks the pair as
//   matched or holds it face-up for SHOW_CYCLES clocks with `par` high. The
//   falling edge of `par` tells the downstream clearing stage to hide the
//   cards indexed by selected1/selected2, which are still valid on that edge.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sel_valid    one-cycle pulse: player selected card sel_idx
//   sel_idx      index 0..15 of the selected card
//   board        card symbols, card i at [i*SYM_W +: SYM_W]
//   selected1    first card of current turn, 8'hFF = none
//   selected2    second card of current turn, 8'hFF = none
//   par          high while a mismatched pair is displayed
//   revealed     card i face-up and not yet matched
//   matched      card i permanently matched
//   pairs_found  matched pairs, 0..8
//   attempts     completed turns, saturating at 255
//   game_done    all pairs matched
// ---------------------------------------------------------------------------
module pair_select_fsm #(
  parameter int N_CARDS     = 16,
  parameter int SYM_W       = 4,
  parameter int SHOW_CYCLES = 50000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sel_valid,
  input  logic [3:0]               sel_idx,
  input  logic [N_CARDS*SYM_W-1:0] board,
  output logic [7:0]               selected1,
  output logic [7:0]               selected2,
  output logic                     par,
  output logic [N_CARDS-1:0]       revealed,
  output logic [N_CARDS-1:0]       matched,
  output logic [3:0]               pairs_found,
  output logic [7:0]               attempts,
  output logic                     game_done
);

  localparam int              TMR_W     = $clog2(SHOW_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [7:0]      NONE      = 8'hFF;
  localparam logic [3:0]      ALL_PAIRS = 4'(N_CARDS / 2);

  typedef enum logic [2:0] {IDLE, ONE, CMP, SHOW, DONE} state_t;

  state_t               state, state_n;
  logic [TMR_W-1:0]     timer, timer_n;
  logic [7:0]           sel1_n, sel2_n;
  logic                 par_n;
  logic [N_CARDS-1:0]   revealed_n, matched_n;
  logic [3:0]           pairs_n;
  logic [7:0]           attempts_n;
  logic                 done_n;

  logic [SYM_W-1:0]     sym [N_CARDS];
  logic [3:0]           idx1, idx2;
  logic                 legal;
  logic                 sym_eq;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_CARDS; i++) sym[i] = board[i*SYM_W +: SYM_W];
  end

  assign idx1   = selected1[3:0];
  assign idx2   = selected2[3:0];
  assign sym_eq = (sym[idx1] == sym[idx2]);
  // A card already face-up or matched cannot be picked; this also rejects
  // re-selecting the first card of the turn.
  assign legal  = sel_valid && !matched[sel_idx] && !revealed[sel_idx];

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    sel1_n     = selected1;
    sel2_n     = selected2;
    par_n      = par;
    revealed_n = revealed;
    matched_n  = matched;
    pairs_n    = pairs_found;
    attempts_n = attempts;
    done_n     = game_done;

    case (state)
      IDLE: begin
        // Indices from a finished SHOW linger one cycle, then fall to none.
        sel2_n = NONE;
        if (legal) begin
          sel1_n              = {4'd0, sel_idx};
          revealed_n[sel_idx] = 1'b1;
          state_n             = ONE;
        end else begin
          sel1_n = NONE;
        end
      end
      ONE: begin
        if (legal) begin
          sel2_n              = {4'd0, sel_idx};
          revealed_n[sel_idx] = 1'b1;
          state_n             = CMP;
        end
      end
      CMP: begin
        attempts_n = sat_inc8(attempts);
        if (sym_eq) begin
          matched_n[idx1]  = 1'b1;
          matched_n[idx2]  = 1'b1;
          revealed_n[idx1] = 1'b0;
          revealed_n[idx2] = 1'b0;
          pairs_n          = pairs_found + 4'd1;
          sel1_n           = NONE;
          sel2_n           = NONE;
          if (pairs_n == ALL_PAIRS) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          par_n   = 1'b1;
          timer_n = TMR_LOAD;
          state_n = SHOW;
        end
      end
      SHOW: begin
        if (timer == '0) begin
          par_n            = 1'b0;
          revealed_n[idx1] = 1'b0;
          revealed_n[idx2] = 1'b0;
          state_n          = IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---- state / output register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      selected1   <= NONE;
      selected2   <= NONE;
      par         <= 1'b0;
      revealed    <= '0;
      matched     <= '0;
      pairs_found <= 4'd0;
      attempts    <= 8'd0;
      game_done   <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      selected1   <= sel1_n;
      selected2   <= sel2_n;
      par         <= par_n;
      revealed    <= revealed_n;
      matched     <= matched_n;
      pairs_found <= pairs_n;
      attempts    <= attempts_n;
      game_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_pair_select_fsm.sv
// ---------------------------------------------------------------------------
// tb_pair_select_fsm
//   Directed bench for pair_select_fsm with SHOW_CYCLES = 4. Inputs change on
//   the falling clock edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pair_select_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_valid = 1'b0;
  logic [3:0]  sel_idx = 4'd0;
  logic [63:0] board;
  logic [7:0]  selected1, selected2;
  logic        par;
  logic [15:0] revealed, matched;
  logic [3:0]  pairs_found;
  logic [7:0]  attempts;
  logic        game_done;

  int checks = 0;
  int failures = 0;

  pair_select_fsm #(.N_CARDS(16), .SYM_W(4), .SHOW_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_idx(sel_idx),
    .board(board), .selected1(selected1), .selected2(selected2), .par(par),
    .revealed(revealed), .matched(matched), .pairs_found(pairs_found),
    .attempts(attempts), .game_done(game_done)
  );

  always #5 clk = ~clk;

  // Pairs: (0,8)=1 (1,10)=2 (2,11)=3 (3,9)=5 (4,12)=4 (5,13)=6 (6,14)=7 (7,15)=0
  logic [3:0] syms [16] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd6, 4'd7, 4'd0,
                            4'd1, 4'd5, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pick(input logic [3:0] i);
    @(negedge clk);
    sel_valid = 1'b1;
    sel_idx   = i;
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic turn(input logic [3:0] a, input logic [3:0] b);
    pick(a);
    pick(b);
    idle_cycles(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) board[i*4 +: 4] = syms[i];

    // Reset state
    do_reset();
    chk("rst_sel1", 32'(selected1), 32'hFF);
    chk("rst_sel2", 32'(selected2), 32'hFF);
    chk("rst_par", 32'(par), 0);
    chk("rst_revealed", 32'(revealed), 0);
    chk("rst_matched", 32'(matched), 0);
    chk("rst_pairs", 32'(pairs_found), 0);
    chk("rst_attempts", 32'(attempts), 0);
    chk("rst_done", 32'(game_done), 0);

    // 1. Matched pair 3/9
    pick(4'd3);
    chk("m_sel1", 32'(selected1), 3);
    chk("m_sel2_none", 32'(selected2), 32'hFF);
    chk("m_rev1", 32'(revealed), 32'h0008);
    pick(4'd9);
    chk("m_sel2", 32'(selected2), 9);
    chk("m_rev2", 32'(revealed), 32'h0208);
    chk("m_matched_early", 32'(matched), 0);
    @(negedge clk);
    chk("m_matched", 32'(matched), 32'h0208);
    chk("m_rev_clr", 32'(revealed), 0);
    chk("m_pairs", 32'(pairs_found), 1);
    chk("m_attempts", 32'(attempts), 1);
    chk("m_sel1_ff", 32'(selected1), 32'hFF);
    chk("m_sel2_ff", 32'(selected2), 32'hFF);
    chk("m_par", 32'(par), 0);

    // 3. Illegal selections (continuing with 3/9 matched)
    pick(4'd4);
    pick(4'd4);
    chk("il_resel_sel1", 32'(selected1), 4);
    chk("il_resel_sel2", 32'(selected2), 32'hFF);
    chk("il_resel_rev", 32'(revealed), 32'h0010);
    pick(4'd3);
    chk("il_matched_sel2", 32'(selected2), 32'hFF);
    chk("il_matched_rev", 32'(revealed), 32'h0010);
    pick(4'd5);
    @(negedge clk);
    chk("il_show_par", 32'(par), 1);
    pick(4'd6);
    chk("il_show_rev", 32'(revealed), 32'h0030);
    chk("il_show_sel2", 32'(selected2), 5);
    begin
      int n = 0;
      while (par && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("il_par_drop", 32'(par), 0);
    end
    idle_cycles(2);
    chk("il_rev_end", 32'(revealed), 0);
    chk("il_attempts", 32'(attempts), 2);
    chk("il_pairs", 32'(pairs_found), 1);

    // 2. Mismatch 0/1
    do_reset();
    pick(4'd0);
    pick(4'd1);
    chk("mm_par_lat", 32'(par), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mm_par_high", 32'(par), 1);
    end
    chk("mm_edge_sel1", 32'(selected1), 0);
    chk("mm_edge_sel2", 32'(selected2), 1);
    chk("mm_edge_rev", 32'(revealed), 32'h0003);
    @(negedge clk);
    chk("mm_par_low", 32'(par), 0);
    chk("mm_rev_clr", 32'(revealed), 0);
    chk("mm_hold_sel1", 32'(selected1), 0);
    chk("mm_hold_sel2", 32'(selected2), 1);
    @(negedge clk);
    chk("mm_sel1_ff", 32'(selected1), 32'hFF);
    chk("mm_sel2_ff", 32'(selected2), 32'hFF);
    chk("mm_attempts", 32'(attempts), 1);

    // 4. Asynchronous reset while par is high
    do_reset();
    pick(4'd0);
    pick(4'd1);
    @(negedge clk);
    chk("ar_par_before", 32'(par), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_par", 32'(par), 0);
    chk("ar_rev", 32'(revealed), 0);
    chk("ar_sel1", 32'(selected1), 32'hFF);
    chk("ar_sel2", 32'(selected2), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    // 5. Full game: 8 matches, 3 mismatches
    do_reset();
    turn(4'd0, 4'd8);
    turn(4'd1, 4'd2);
    turn(4'd1, 4'd10);
    turn(4'd2, 4'd11);
    turn(4'd4, 4'd5);
    turn(4'd4, 4'd12);
    turn(4'd5, 4'd13);
    turn(4'd6, 4'd7);
    turn(4'd6, 4'd14);
    turn(4'd3, 4'd9);
    turn(4'd7, 4'd15);
    chk("fg_pairs", 32'(pairs_found), 8);
    chk("fg_attempts", 32'(attempts), 11);
    chk("fg_done", 32'(game_done), 1);
    chk("fg_matched", 32'(matched), 32'hFFFF);
    chk("fg_rev", 32'(revealed), 0);
    pick(4'd0);
    pick(4'd5);
    idle_cycles(2);
    chk("fg_after_sel1", 32'(selected1), 32'hFF);
    chk("fg_after_attempts", 32'(attempts), 11);
    chk("fg_after_rev", 32'(revealed), 0);
    chk("fg_after_done", 32'(game_done), 1);

    // 6. Attempts saturation
    do_reset();
    for (int t = 0; t < 260; t++) turn(4'd0, 4'd1);
    chk("sat_attempts", 32'(attempts), 255);
    chk("sat_pairs", 32'(pairs_found), 0);
    chk("sat_matched", 32'(matched), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
